mem_port_sched: RTL and testbench

- Shares one memory port (mem_req / mem_resp decoupled pair) between N requesters: instruction fetch, load/store unit, and future ports.
- Arbitration is round-robin. Responses return in order and are routed back to the originating requester through an in-flight ID FIFO.
- A per-requester flush discards responses still owed to a requester that has been redirected.
- Sits between the pipeline stages and the memory/bus bridge.

---
 rtl/mem_port_sched_pkg.sv | 27 ++
 rtl/mem_port_sched_if.sv | 43 ++++
 rtl/mem_port_sched_inflight_id_fifo.sv | 76 +++++++
 rtl/mem_port_sched.sv | 137 +++++++++++++
 tb/tb_mem_port_sched.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_port_sched_pkg
// Brief    : Shared request/response types and helpers for the memory port scheduler.
// Revision : 1.0
// ============================================================================
package mem_port_sched_pkg;

    localparam int c_N_REQ = 2;
    localparam int c_ID_W  = (c_N_REQ > 1) ? $clog2(c_N_REQ) : 1;

    typedef logic [31:0]       gpreg;
    typedef logic [c_ID_W-1:0] mem_id_t;

    typedef struct packed {
        logic [31:0] a;
        logic        we;
        logic [3:0]  be;
        gpreg        d;
    } mem_req_t;

    function automatic int wrap_inc(input int value, input int modulus);
        return (value + 1 >= modulus) ? 0 : value + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_sched_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_port_sched_if
// Brief     : Requester-side and memory-side handshakes of the port scheduler.
// Revision  : 1.0
// ============================================================================
interface mem_port_sched_if
    import mem_port_sched_pkg::*;
#(
    parameter int N_REQ = c_N_REQ
) ();

    logic     [N_REQ-1:0] req_valid;
    logic     [N_REQ-1:0] req_ready;
    mem_req_t [N_REQ-1:0] req_data;
    logic     [N_REQ-1:0] resp_valid;
    logic     [N_REQ-1:0] resp_ready;
    gpreg     [N_REQ-1:0] resp_data;
    logic     [N_REQ-1:0] flush;

    logic     mem_req_valid;
    logic     mem_req_ready;
    mem_req_t mem_req_data;
    logic     mem_resp_valid;
    logic     mem_resp_ready;
    gpreg     mem_resp_data;

    modport slave (
        input  req_valid, req_data, resp_ready, flush,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, resp_valid, resp_data,
        output mem_req_valid, mem_req_data, mem_resp_ready
    );

    modport master (
        output req_valid, req_data, resp_ready, flush,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, resp_valid, resp_data,
        input  mem_req_valid, mem_req_data, mem_resp_ready
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_sched_inflight_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_sched_inflight_id_fifo
// Brief    : Sync FIFO of {id, discard} with a broadcast mark-discard-by-id port.
// Revision : 1.0
// ============================================================================
module mem_port_sched_inflight_id_fifo
    import mem_port_sched_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int ID_W  = 1,
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [ID_W-1:0]  push_id,
    input  logic             push_discard,
    input  logic             pop,
    input  logic [N_REQ-1:0] mark_mask,
    output logic             full,
    output logic             empty,
    output logic [ID_W-1:0]  head_id,
    output logic             head_discard
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0][ID_W-1:0] r_id;
    logic [DEPTH-1:0]           r_disc;
    logic [c_PTR_W-1:0]         r_wr;
    logic [c_PTR_W-1:0]         r_rd;
    logic [c_CNT_W-1:0]         r_cnt;
    logic                       w_push;
    logic                       w_pop;

    assign full         = (r_cnt == c_CNT_W'(DEPTH));
    assign empty        = (r_cnt == '0);
    assign head_id      = r_id[r_rd];
    assign head_discard = r_disc[r_rd];
    assign w_push       = push && !full;
    assign w_pop        = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_id   <= '0;
            r_disc <= '0;
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
        end else begin
            // A freshly pushed slot takes push_discard, overriding any mark on stale contents.
            for (int e = 0; e < DEPTH; e++) begin
                if (mark_mask[r_id[e]]) begin
                    r_disc[e] <= 1'b1;
                end
            end
            if (w_push) begin
                r_id[r_wr]   <= push_id;
                r_disc[r_wr] <= push_discard;
                r_wr         <= c_PTR_W'(wrap_inc(int'(r_wr), DEPTH));
            end
            if (w_pop) begin
                r_rd <= c_PTR_W'(wrap_inc(int'(r_rd), DEPTH));
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_sched.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_sched
// Brief    : Round-robin share of one memory port with in-order response routing.
// Revision : 1.0
// ============================================================================
module mem_port_sched
    import mem_port_sched_pkg::*;
#(
    parameter int N_REQ           = c_N_REQ,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ID_W            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_port_sched_if.slave bus
);

    logic [ID_W-1:0]  r_rr;
    logic [ID_W-1:0]  r_grant;
    logic             r_lock;
    logic             r_lock_flush;
    mem_req_t         r_held;

    logic [ID_W-1:0]  w_grant;
    logic [ID_W-1:0]  w_cand;
    logic             w_found;
    logic             w_full;
    logic             w_empty;
    logic [ID_W-1:0]  w_head_id;
    logic             w_head_disc;
    logic             w_mem_req_valid;
    mem_req_t         w_mem_req_data;
    logic             w_hs;
    logic             w_pop;
    logic             w_push_disc;
    logic [N_REQ-1:0] w_req_ready;
    logic [N_REQ-1:0] w_resp_valid;
    logic             w_mem_resp_ready;

    always_comb begin
        w_grant = r_rr;
        w_cand  = r_rr;
        w_found = 1'b0;
        if (r_lock) begin
            w_grant = r_grant;
            w_found = 1'b1;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                w_cand = ID_W'((int'(r_rr) + k) % N_REQ);
                if (!w_found && bus.req_valid[w_cand]) begin
                    w_grant = w_cand;
                    w_found = 1'b1;
                end
            end
        end
    end

    // Once stalled, the latched request is replayed untouched even if its owner is flushed.
    assign w_mem_req_valid = rst && (r_lock || (w_found && !w_full && !bus.flush[w_grant]));
    assign w_mem_req_data  = r_lock ? r_held : bus.req_data[w_grant];
    assign w_hs            = w_mem_req_valid && bus.mem_req_ready;
    assign w_push_disc     = bus.flush[w_grant] || r_lock_flush;
    assign w_pop           = bus.mem_resp_valid && w_mem_resp_ready;

    always_comb begin
        w_req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_req_ready[i] = rst && (w_grant == ID_W'(i)) && bus.mem_req_ready
                             && !w_full && !bus.flush[i];
        end
    end

    always_comb begin
        w_resp_valid     = '0;
        w_mem_resp_ready = 1'b0;
        if (rst && !w_empty) begin
            if (w_head_disc || bus.flush[w_head_id]) begin
                w_mem_resp_ready = 1'b1;
            end else begin
                w_resp_valid[w_head_id] = bus.mem_resp_valid;
                w_mem_resp_ready        = bus.resp_ready[w_head_id];
            end
        end
    end

    assign bus.mem_req_valid  = w_mem_req_valid;
    assign bus.mem_req_data   = w_mem_req_data;
    assign bus.req_ready      = w_req_ready;
    assign bus.resp_valid     = w_resp_valid;
    assign bus.mem_resp_ready = w_mem_resp_ready;
    assign bus.resp_data      = {N_REQ{bus.mem_resp_data}};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr         <= '0;
            r_grant      <= '0;
            r_lock       <= 1'b0;
            r_lock_flush <= 1'b0;
            r_held       <= '0;
        end else if (w_hs) begin
            r_rr         <= ID_W'(wrap_inc(int'(w_grant), N_REQ));
            r_lock       <= 1'b0;
            r_lock_flush <= 1'b0;
        end else if (w_mem_req_valid) begin
            r_lock  <= 1'b1;
            r_grant <= w_grant;
            r_held  <= w_mem_req_data;
            if (bus.flush[w_grant]) begin
                r_lock_flush <= 1'b1;
            end
        end
    end

    mem_port_sched_inflight_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .ID_W  (ID_W),
        .N_REQ (N_REQ)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (w_hs),
        .push_id      (w_grant),
        .push_discard (w_push_disc),
        .pop          (w_pop),
        .mark_mask    (bus.flush),
        .full         (w_full),
        .empty        (w_empty),
        .head_id      (w_head_id),
        .head_discard (w_head_disc)
    );

    a_no_resp_when_empty: assert property (@(posedge clk) disable iff (!rst)
        !(bus.mem_resp_valid && w_empty));

endmodule
`default_nettype wire

// File: tb/tb_mem_port_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_sched
// Brief    : Directed scenarios plus randomized run against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_sched;
    import mem_port_sched_pkg::*;

    localparam int c_N   = 2;
    localparam int c_MAX = 2;

    typedef struct { int id; bit disc; } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mem_port_sched_if #(.N_REQ(c_N)) bus ();

    mem_port_sched #(.N_REQ(c_N), .MAX_OUTSTANDING(c_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.req_valid      = '0;
        bus.req_data       = '0;
        bus.resp_ready     = '1;
        bus.flush          = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a);
        mem_req_t r;
        r.a = a; r.we = 1'b0; r.be = 4'hF; r.d = 32'h0;
        bus.req_data[i] = r;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = '1; bus.mem_req_ready = 1'b1; bus.resp_ready = '1;
        @(negedge clk); #1;
        checks++; if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_req_valid got=%b exp=0", bus.mem_req_valid); end
        checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready); end
        checks++; if (bus.resp_valid !== 2'b00) begin failures++; $display("FAIL reset_resp_valid got=%b exp=00", bus.resp_valid); end
        checks++; if (bus.mem_resp_ready !== 1'b0) begin failures++; $display("FAIL reset_mem_resp_ready got=%b exp=0", bus.mem_resp_ready); end
    endtask

    task automatic test_single();
        apply_reset();
        set_req(0, 32'h100); bus.req_valid = 2'b01; bus.mem_req_ready = 1'b1; #1;
        checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_data.a !== 32'h100) begin failures++; $display("FAIL single_req got v=%b a=%h exp v=1 a=100", bus.mem_req_valid, bus.mem_req_data.a); end
        checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL single_req_ready got=%b exp=01", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hDEADBEEF; #1;
        checks++; if (bus.resp_valid !== 2'b01 || bus.resp_data[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL single_resp got v=%b d=%h exp v=01 d=deadbeef", bus.resp_valid, bus.resp_data[0]); end
        checks++; if (bus.mem_resp_ready !== 1'b1) begin failures++; $display("FAIL single_mem_resp_ready got=%b exp=1", bus.mem_resp_ready); end
        @(negedge clk);
        bus.mem_resp_valid = 1'b0; #1;
        checks++; if (bus.mem_resp_ready !== 1'b0) begin failures++; $display("FAIL single_empty_ready got=%b exp=0", bus.mem_resp_ready); end
    endtask

    task automatic test_round_robin();
        int q[$];
        int exp_g;
        apply_reset();
        set_req(0, 32'h200); set_req(1, 32'h201);
        bus.req_valid = 2'b11; bus.mem_req_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            exp_g = c % 2;
            if (c == 4) bus.req_valid = '0;
            bus.mem_resp_valid = (q.size() > 0);
            bus.mem_resp_data  = $urandom;
            #1;
            if (c < 4) begin
                checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_data.a !== 32'(32'h200 + exp_g)) begin failures++; $display("FAIL rr_grant c=%0d got v=%b a=%h exp a=%h", c, bus.mem_req_valid, bus.mem_req_data.a, 32'h200 + exp_g); end
            end
            if (q.size() > 0) begin
                checks++; if (bus.resp_valid !== 2'(1 << q[0]) || bus.resp_data[q[0]] !== bus.mem_resp_data) begin failures++; $display("FAIL rr_route c=%0d got=%b exp=%b", c, bus.resp_valid, 2'(1 << q[0])); end
                void'(q.pop_front());
            end
            if (c < 4) q.push_back(exp_g);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_backpressure();
        apply_reset();
        set_req(0, 32'h300); set_req(1, 32'h301);
        bus.req_valid = 2'b11; bus.mem_req_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_data.a !== 32'h300 || bus.req_ready !== 2'b00) begin failures++; $display("FAIL bp_hold c=%0d got v=%b a=%h rdy=%b exp v=1 a=300 rdy=00", c, bus.mem_req_valid, bus.mem_req_data.a, bus.req_ready); end
        end
        @(negedge clk);
        bus.mem_req_ready = 1'b1; #1;
        checks++; if (bus.mem_req_data.a !== 32'h300 || bus.req_ready !== 2'b01) begin failures++; $display("FAIL bp_release got a=%h rdy=%b exp a=300 rdy=01", bus.mem_req_data.a, bus.req_ready); end
        @(negedge clk); #1;
        checks++; if (bus.mem_req_data.a !== 32'h301 || bus.req_ready !== 2'b10) begin failures++; $display("FAIL bp_next got a=%h rdy=%b exp a=301 rdy=10", bus.mem_req_data.a, bus.req_ready); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        apply_reset();
        set_req(0, 32'h400); bus.req_valid = 2'b01; bus.mem_req_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL full_accept c=%0d got=%b exp=01", c, bus.req_ready); end
        end
        @(negedge clk); #1;
        checks++; if (bus.req_ready !== 2'b00 || bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL full_block got rdy=%b v=%b exp rdy=00 v=0", bus.req_ready, bus.mem_req_valid); end
        @(negedge clk);
        bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0BAD_F00D; #1;
        checks++; if (bus.req_ready !== 2'b00 || bus.resp_valid !== 2'b01) begin failures++; $display("FAIL full_pop_same_cycle got rdy=%b rv=%b exp rdy=00 rv=01", bus.req_ready, bus.resp_valid); end
        @(negedge clk);
        bus.mem_resp_valid = 1'b0; #1;
        checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL full_after_pop got=%b exp=01", bus.req_ready); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_flush();
        apply_reset();
        set_req(0, 32'h500); bus.req_valid = 2'b01; bus.mem_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.flush = 2'b01; #1;
        checks++; if (bus.req_ready !== 2'b00 || bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL flush_block got rdy=%b v=%b exp rdy=00 v=0", bus.req_ready, bus.mem_req_valid); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            bus.flush = '0; bus.req_valid = '0; bus.resp_ready = '0;
            bus.mem_resp_valid = 1'b1; bus.mem_resp_data = $urandom; #1;
            checks++; if (bus.mem_resp_ready !== 1'b1 || bus.resp_valid !== 2'b00) begin failures++; $display("FAIL flush_swallow c=%0d got mrr=%b rv=%b exp mrr=1 rv=00", c, bus.mem_resp_ready, bus.resp_valid); end
        end
        @(negedge clk);
        bus.mem_resp_valid = 1'b0; bus.resp_ready = '1; bus.req_valid = 2'b01; #1;
        checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL flush_new_req got=%b exp=01", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h1234_5678; #1;
        checks++; if (bus.resp_valid !== 2'b01 || bus.resp_data[0] !== 32'h1234_5678 || bus.mem_resp_ready !== 1'b1) begin failures++; $display("FAIL flush_after got rv=%b d=%h exp rv=01 d=12345678", bus.resp_valid, bus.resp_data[0]); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_req(0, 32'h600); set_req(1, 32'h601);
        bus.req_valid = 2'b01; bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 2'b10; bus.mem_req_ready = 1'b0; #1;
        checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_data.a !== 32'h601) begin failures++; $display("FAIL mid_lock got v=%b a=%h exp v=1 a=601", bus.mem_req_valid, bus.mem_req_data.a); end
        @(negedge clk);
        rst = 1'b0; #1;
        checks++; if (bus.mem_req_valid !== 1'b0 || bus.mem_resp_ready !== 1'b0 || bus.req_ready !== 2'b00) begin failures++; $display("FAIL mid_in_reset got v=%b mrr=%b rdy=%b exp 0/0/00", bus.mem_req_valid, bus.mem_resp_ready, bus.req_ready); end
        @(negedge clk);
        rst = 1'b1; bus.req_valid = 2'b11; bus.resp_ready = '1; #1;
        checks++; if (bus.mem_req_data.a !== 32'h600 || bus.mem_resp_ready !== 1'b0) begin failures++; $display("FAIL mid_after got a=%h mrr=%b exp a=600 mrr=0", bus.mem_req_data.a, bus.mem_resp_ready); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        ent_t       q[$];
        int         rr = 0;
        bit         locked = 1'b0;
        int         lock_id = 0;
        bit         lock_fl = 1'b0;
        mem_req_t   held = '0;
        int         g;
        bit         any;
        bit         exp_mv;
        mem_req_t   exp_md;
        logic [c_N-1:0] exp_rdy;
        logic [c_N-1:0] exp_rv;
        bit         exp_mrr;
        bit         hs;
        bit         pop;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc > 0) @(negedge clk);
            for (int i = 0; i < c_N; i++) begin
                if (locked && i == lock_id) begin
                    bus.req_valid[i] = 1'b1;
                end else begin
                    bus.req_valid[i] = ($urandom_range(0, 3) != 0);
                    bus.req_data[i]  = {$urandom, 1'($urandom), 4'($urandom), $urandom};
                end
                bus.flush[i]      = ($urandom_range(0, 9) == 0);
                bus.resp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            bus.mem_req_ready  = ($urandom_range(0, 2) != 0);
            bus.mem_resp_valid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            bus.mem_resp_data  = $urandom;
            #1;
            any = 1'b0; g = rr;
            if (locked) begin
                g = lock_id; any = 1'b1;
            end else begin
                for (int k = 0; k < c_N; k++) begin
                    if (!any && bus.req_valid[(rr + k) % c_N]) begin g = (rr + k) % c_N; any = 1'b1; end
                end
            end
            exp_mv = locked || (any && q.size() < c_MAX && !bus.flush[g]);
            exp_md = locked ? held : bus.req_data[g];
            for (int i = 0; i < c_N; i++)
                exp_rdy[i] = (i == g) && bus.mem_req_ready && (q.size() < c_MAX) && !bus.flush[i];
            exp_rv = '0; exp_mrr = 1'b0;
            if (q.size() > 0) begin
                if (q[0].disc || bus.flush[q[0].id]) exp_mrr = 1'b1;
                else begin exp_rv[q[0].id] = bus.mem_resp_valid; exp_mrr = bus.resp_ready[q[0].id]; end
            end
            checks++; if (bus.mem_req_valid !== exp_mv) begin failures++; $display("FAIL rand_mem_req_valid cyc=%0d got=%b exp=%b", cyc, bus.mem_req_valid, exp_mv); end
            if (exp_mv) begin
                checks++; if (bus.mem_req_data !== exp_md) begin failures++; $display("FAIL rand_mem_req_data cyc=%0d got=%h exp=%h", cyc, bus.mem_req_data, exp_md); end
            end
            checks++; if ((bus.req_ready & bus.req_valid) !== (exp_rdy & bus.req_valid)) begin failures++; $display("FAIL rand_req_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready & bus.req_valid, exp_rdy & bus.req_valid); end
            checks++; if (bus.resp_valid !== exp_rv) begin failures++; $display("FAIL rand_resp_valid cyc=%0d got=%b exp=%b", cyc, bus.resp_valid, exp_rv); end
            checks++; if (bus.mem_resp_ready !== exp_mrr) begin failures++; $display("FAIL rand_mem_resp_ready cyc=%0d got=%b exp=%b", cyc, bus.mem_resp_ready, exp_mrr); end
            if (exp_rv != '0) begin
                checks++; if (bus.resp_data[q[0].id] !== bus.mem_resp_data) begin failures++; $display("FAIL rand_resp_data cyc=%0d got=%h exp=%h", cyc, bus.resp_data[q[0].id], bus.mem_resp_data); end
            end
            hs  = exp_mv && bus.mem_req_ready;
            pop = bus.mem_resp_valid && exp_mrr;
            foreach (q[j]) if (bus.flush[q[j].id]) q[j].disc = 1'b1;
            if (pop) void'(q.pop_front());
            if (hs) begin
                q.push_back('{id: g, disc: (bus.flush[g] || lock_fl)});
                rr = (g + 1) % c_N; locked = 1'b0; lock_fl = 1'b0;
            end else if (exp_mv) begin
                if (!locked) begin held = exp_md; lock_id = g; end
                locked  = 1'b1;
                lock_fl = lock_fl || bus.flush[g];
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_fifo_full();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
